// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared board-level constants for the input front end
package board_pkg;

  localparam int N_SW                    = 4;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
  localparam int RST_HOLD_DEFAULT        = 16;
  // Short debounce window so benches settle in a handful of cycles
  localparam int DEBOUNCE_CYCLES_SIM     = 4;

endpackage

// File: rtl/input_conditioner_if.sv
// rtl/input_conditioner_if.sv - switch and reset signals between board pins and core logic
interface input_conditioner_if
  import board_pkg::*;
();

  logic [N_SW-1:0] switch_raw;
  logic            sys_reset;
  logic [N_SW-1:0] switch_clean;
  logic [N_SW-1:0] switch_rise;
  logic [N_SW-1:0] switch_fall;

  modport master (
    output switch_raw,
    input  sys_reset,
    input  switch_clean,
    input  switch_rise,
    input  switch_fall
  );

  modport slave (
    input  switch_raw,
    output sys_reset,
    output switch_clean,
    output switch_rise,
    output switch_fall
  );

endinterface

// File: rtl/input_conditioner_debounce_bit.sv
// rtl/input_conditioner_debounce_bit.sv - two-flop synchroniser, debounce counter and edge pulses for one switch
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic suppress,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Any sample matching the current level discards all progress toward a change
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = s2_q;
      cnt_d   = '0;
      rise_d  = s2_q & ~suppress;
      fall_d  = ~s2_q & ~suppress;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - debounces board switches and stretches board reset into sys_reset
module input_conditioner
  import board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int RST_HOLD        = RST_HOLD_DEFAULT
) (
  input logic                 clk,
  input logic                 reset,
  input_conditioner_if.slave  sw
);

  localparam int            RW        = $clog2(RST_HOLD + 1);
  localparam logic [RW-1:0] RCNT_HOLD = RW'(RST_HOLD);

  logic [RW-1:0]   rcnt_q, rcnt_d;
  logic            sys_reset_q, sys_reset_d;
  logic [N_SW-1:0] clean_w, rise_w, fall_w;

  always_comb begin
    rcnt_d      = rcnt_q;
    sys_reset_d = sys_reset_q;
    if (reset) begin
      rcnt_d      = '0;
      sys_reset_d = 1'b1;
    end else begin
      rcnt_d      = (rcnt_q == RCNT_HOLD) ? rcnt_q : rcnt_q + 1'b1;
      sys_reset_d = (rcnt_d != RCNT_HOLD);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt_q      <= '0;
      sys_reset_q <= 1'b1;
    end else begin
      rcnt_q      <= rcnt_d;
      sys_reset_q <= sys_reset_d;
    end
  end

  // Next-state reset gates edges so a pulse never coexists with sys_reset high
  for (genvar i = 0; i < N_SW; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .reset    (reset),
      .raw      (sw.switch_raw[i]),
      .suppress (sys_reset_d),
      .level    (clean_w[i]),
      .rise     (rise_w[i]),
      .fall     (fall_w[i])
    );
  end

  assign sw.sys_reset    = sys_reset_q;
  assign sw.switch_clean = clean_w;
  assign sw.switch_rise  = rise_w;
  assign sw.switch_fall  = fall_w;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - table-driven bench for input_conditioner
module tb_input_conditioner;
  import board_pkg::*;

  typedef struct {
    logic       rst;
    logic [3:0] raw;
    logic       sys;
    logic [3:0] clean;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[$];

  input_conditioner_if ifc ();
  input_conditioner_if ifc2 ();

  input_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_SIM),
    .RST_HOLD       (3)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .sw    (ifc)
  );

  // Long reset hold so acceptance happens while sys_reset is still high
  input_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_SIM),
    .RST_HOLD       (10)
  ) dut2 (
    .clk   (clk),
    .reset (rst2),
    .sw    (ifc2)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] raw, input logic sys,
                     input logic [3:0] c, input logic [3:0] ri, input logic [3:0] fa,
                     input int n);
    for (int i = 0; i < n; i++) vecs.push_back('{rst: r, raw: raw, sys: sys, clean: c, rise: ri, fall: fa});
  endtask

  task automatic chk(input string name, input int idx, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] raw);
    @(negedge clk);
    rst = r;
    ifc.switch_raw = raw;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string name, input int idx, input logic sys,
                               input logic [3:0] c, input logic [3:0] ri, input logic [3:0] fa);
    chk({name, "_sys"},   idx, {3'b000, ifc.sys_reset}, {3'b000, sys});
    chk({name, "_clean"}, idx, ifc.switch_clean, c);
    chk({name, "_rise"},  idx, ifc.switch_rise, ri);
    chk({name, "_fall"},  idx, ifc.switch_fall, fa);
  endtask

  // One reset cycle with raw held at f, then the full re-acceptance window
  task automatic release_check(input string name, input logic [3:0] f);
    for (int j = 0; j < 10; j++) begin
      step(j == 0, f);
      check_outputs(name, j, j < 3, (j >= 6) ? f : 4'b0000, (j == 6) ? f : 4'b0000, 4'b0000);
    end
  endtask

  initial begin
    rst = 1'b1;
    ifc.switch_raw = 4'b0000;
    rst2 = 1'b1;
    ifc2.switch_raw = 4'b1111;

    add(1, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 5);
    add(0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 2);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 2);
    add(0, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 5);
    add(0, 4'b0001, 0, 4'b0001, 4'b0001, 4'b0000, 1);
    add(0, 4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 1);
    add(0, 4'b0011, 0, 4'b0001, 4'b0000, 4'b0000, 1);
    add(0, 4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 1);
    add(0, 4'b0011, 0, 4'b0001, 4'b0000, 4'b0000, 1);
    add(0, 4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 1);
    add(0, 4'b0011, 0, 4'b0001, 4'b0000, 4'b0000, 5);
    add(0, 4'b0011, 0, 4'b0011, 4'b0010, 4'b0000, 1);
    add(0, 4'b0011, 0, 4'b0011, 4'b0000, 4'b0000, 1);
    add(0, 4'b1011, 0, 4'b0011, 4'b0000, 4'b0000, 5);
    add(0, 4'b1011, 0, 4'b1011, 4'b1000, 4'b0000, 1);
    add(0, 4'b1011, 0, 4'b1011, 4'b0000, 4'b0000, 1);
    add(0, 4'b0010, 0, 4'b1011, 4'b0000, 4'b0000, 5);
    add(0, 4'b0010, 0, 4'b0010, 4'b0000, 4'b1001, 1);
    add(0, 4'b0010, 0, 4'b0010, 4'b0000, 4'b0000, 1);
    add(0, 4'b0110, 0, 4'b0010, 4'b0000, 4'b0000, 3);
    add(0, 4'b0010, 0, 4'b0010, 4'b0000, 4'b0000, 5);
    add(0, 4'b0110, 0, 4'b0010, 4'b0000, 4'b0000, 4);
    add(0, 4'b0010, 0, 4'b0010, 4'b0000, 4'b0000, 1);
    add(0, 4'b0010, 0, 4'b0110, 4'b0100, 4'b0000, 1);
    add(0, 4'b0010, 0, 4'b0110, 4'b0000, 4'b0000, 3);
    add(0, 4'b0010, 0, 4'b0010, 4'b0000, 4'b0100, 1);
    add(0, 4'b0010, 0, 4'b0010, 4'b0000, 4'b0000, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].raw);
      check_outputs("vec", i, vecs[i].sys, vecs[i].clean, vecs[i].rise, vecs[i].fall);
    end

    release_check("held_thru_rst", 4'b1111);

    step(1'b1, 4'b0000);
    for (int j = 0; j < 6; j++) step(1'b0, 4'b0000);
    for (int j = 0; j < 4; j++) begin
      step(1'b0, 4'b0001);
      check_outputs("pending", j, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    end
    release_check("rst_mid", 4'b0001);

    for (int j = 0; j < 13; j++) begin
      @(negedge clk);
      rst2 = 1'b0;
      @(posedge clk);
      #1;
      chk("long_sys",   j, {3'b000, ifc2.sys_reset}, {3'b000, j < 9});
      chk("long_clean", j, ifc2.switch_clean, (j >= 5) ? 4'b1111 : 4'b0000);
      chk("long_rise",  j, ifc2.switch_rise, 4'b0000);
      chk("long_fall",  j, ifc2.switch_fall, 4'b0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Board-input front end between the FPGA pins and `top`. It synchronises and debounces the four slide switches and produces clean level, rising-edge and falling-edge signals. It also stretches the board reset into a guaranteed-length `sys_reset` for the CPU and its peripherals. `top_wrapper` instantiates it between its `clk`/`reset`/`switch` pins and `top`'s `pin_reset`/`pin_switch`.

## Interface
- `N_SW`, 4, number of switch inputs
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive stable cycles required to accept a switch change (10 ms at 100 MHz); legal range ≥ 2
- `RST_HOLD`, 16, cycles `sys_reset` stays high after `reset` drops; legal range ≥ 1
- `clk`  in  1  single system clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high; clears all state on the next `clk` edge
- `switch_raw`  in  N_SW  asynchronous board switches
- `sys_reset`  out  1  stretched reset for downstream logic, active-high
- `switch_clean`  out  N_SW  debounced switch level
- `switch_rise`  out  N_SW  one-cycle pulse when `switch_clean[i]` goes 0→1
- `switch_fall`  out  N_SW  one-cycle pulse when `switch_clean[i]` goes 1→0

## Operation
- Reset values: `sys_reset`=1, `switch_clean`=0, `switch_rise`=0, `switch_fall`=0; synchroniser flops, debounce counters and reset counter all 0.
- Per bit, synchroniser: two flops, `s1 <= switch_raw[i]`, `s2 <= s1`. No logic between the flops.
- Per bit, debounce counter `cnt` is `$clog2(DEBOUNCE_CYCLES)` bits wide:
  - if `s2 == switch_clean[i]`: `cnt <= 0`;
  - else if `cnt == DEBOUNCE_CYCLES-1`: `switch_clean[i] <= s2`, `cnt <= 0`;
  - else `cnt <= cnt + 1`.
- Glitch rule: any return of `s2` to the current clean level before the count completes clears `cnt`. There is no partial credit, and the counter never wraps.
- Edge pulses are registered alongside the `switch_clean` update. `switch_rise[i]` is high for exactly the one cycle after `switch_clean[i]` rose; `switch_fall[i]` likewise for a fall. Rise and fall are never both high on the same bit.
- Reset stretcher: `rcnt` is `$clog2(RST_HOLD+1)` bits wide.
  - While `reset`=1: `rcnt <= 0`, `sys_reset <= 1`.
  - Otherwise `rcnt` increments, saturating at `RST_HOLD`.
  - `sys_reset <= (rcnt_next != RST_HOLD)`.
- While `sys_reset`=1, `switch_rise`/`switch_fall` are forced 0. Debouncing still runs, so `switch_clean` reflects the real switch positions when `sys_reset` drops, with no spurious edges.
- Reset mid-debounce: all counters and levels return to reset values on the next edge. A held-high switch is then re-accepted from scratch after `reset` falls.
- Bits are fully independent. Simultaneous changes on several bits produce simultaneous pulses.

## Timing
- `switch_raw[i]` changes before edge k and then stays stable:
  - `s2` reflects the new value after edge k+1;
  - `switch_clean[i]` and the edge pulse appear after edge k+1+DEBOUNCE_CYCLES;
  - total latency is DEBOUNCE_CYCLES+2 edges.
- `reset` is sampled low first at edge m: `sys_reset` is 0 after edge m+RST_HOLD-1, i.e. RST_HOLD edges with reset low are required.
- A single `reset` cycle still yields a full RST_HOLD-cycle `sys_reset`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `board_pkg`:
  - `N_SW` constant;
  - default `DEBOUNCE_CYCLES` and `RST_HOLD` constants;
  - a sim-speed debounce constant (4) used by benches.
- Sub-module `debounce_bit` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `reset`, `raw`, `suppress`, `level`, `rise`, `fall`):
  - contains the synchroniser, counter and edge logic;
  - generated N_SW times.
- The reset stretcher stays inline in `input_conditioner`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and RST_HOLD=3.
- Reset release: hold `reset`=1 for 5 cycles, then 0 → `sys_reset` high through the 3rd reset-low edge and 0 after it. All other outputs are 0 throughout.
- Clean press: after `sys_reset`=0, set `switch_raw`=4'b0001 before edge k → `switch_clean`=4'b0001 and `switch_rise`=4'b0001 for exactly one cycle after edge k+5. `switch_fall` stays 0.
- Bounce: toggle `switch_raw[1]` 1,0,1,0 on successive cycles, then hold 1 → no pulse during the toggling. `switch_clean[1]` rises 6 edges after the final 0→1 transition.
- Release and multi-bit: drop bits 0 and 3 together from 1 to 0 → `switch_fall`=4'b1001 pulses in a single cycle, and `switch_clean` bits 0 and 3 clear simultaneously.
- Switch held through reset: hold `switch_raw`=4'b1111 while asserting `reset` for 1 cycle → `switch_clean` returns to 0 and then re-accepts 4'b1111. No `switch_rise` pulse appears while `sys_reset`=1; a pulse appears only if acceptance occurs after `sys_reset` falls.
- Reset mid-count: assert `reset` at count 2 of a pending change → after release, the full 4-cycle debounce restarts from 0.
